fetch_prefetch_buffer: RTL and testbench

// Sequential instruction prefetch queue between the datapath fetch port and the memory icache port.

---
 rtl/fetch_prefetch_buffer.sv | 180 ++++++++++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetch queue between the datapath fetch port and
// the memory icache port. Streams PC, PC+INC, ... into a small FIFO while the
// pipeline is busy; a non-sequential fetch flushes the queue and restarts the
// stream at the new PC. Both sides use the same request/ready handshake.
module fetch_prefetch_buffer #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         DEPTH    = 4,
  parameter int unsigned         INC      = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            cpu_PC,
  input  logic                         cpu_instrRequest,
  output logic [DATA_W-1:0]            cpu_instruction,
  output logic                         cpu_instrReady,
  output logic [ADDR_W-1:0]            mem_PC,
  output logic                         mem_instrRequest,
  input  logic [DATA_W-1:0]            mem_instruction,
  input  logic                         mem_instrReady,
  output logic [$clog2(DEPTH+1)-1:0]   pf_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  // Queue storage: each entry remembers the address it was fetched from.
  logic [ADDR_W-1:0] q_addr  [DEPTH];
  logic [DATA_W-1:0] q_instr [DEPTH];

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] pf_addr_q,   pf_addr_d;
  logic [ADDR_W-1:0] mem_pc_q,    mem_pc_d;
  logic              mem_req_q,   mem_req_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic              cpu_rdy_q,   cpu_rdy_d;
  logic [DATA_W-1:0] cpu_instr_q, cpu_instr_d;

  logic              cpu_eval;
  logic              hit;
  logic              pending;
  logic              redirect;
  logic              push;
  logic [ADDR_W-1:0] expected_addr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_instr;

  assign head_addr  = q_addr[rd_ptr_q];
  assign head_instr = q_instr[rd_ptr_q];

  // The address the stream will deliver next: the in-flight one while
  // fetching, otherwise the next prefetch address.
  assign expected_addr = (state_q == ST_FETCH) ? mem_pc_q : pf_addr_q;

  // The pulse cycle is skipped: the datapath is updating its PC on that edge.
  assign cpu_eval = cpu_instrRequest && !cpu_rdy_q;
  assign hit      = cpu_eval && (count_q != '0) && (head_addr == cpu_PC);
  assign pending  = cpu_eval && (count_q == '0) && (cpu_PC == expected_addr);
  assign redirect = cpu_eval && !hit && !pending;

  // Memory-side FSM: one outstanding request at most, never aborted.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_d   = state_q;
    mem_req_d = mem_req_q;
    mem_pc_d  = mem_pc_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect || (count_q < FULL)) begin
          mem_req_d = 1'b1;
          mem_pc_d  = redirect ? cpu_PC : pf_addr_q;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_instrReady) begin
          mem_req_d = 1'b0;
          push      = !redirect;
          state_d   = ST_IDLE;
        end else if (redirect) begin
          state_d   = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (mem_instrReady) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Queue bookkeeping, prefetch address and the CPU-side response.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pf_addr_d   = pf_addr_q;
    cpu_rdy_d   = hit;
    cpu_instr_d = hit ? head_instr : cpu_instr_q;
    if (redirect) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      pf_addr_d = cpu_PC;
    end else begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(hit);
      wr_ptr_d  = wr_ptr_q + PTR_W'(push);
      count_d   = count_q + CNT_W'(push) - CNT_W'(hit);
      if (push) begin
        pf_addr_d = pf_addr_q + INC_V;
      end
    end
  end

  // Control and output registers, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples the same
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state_q     <= ST_IDLE;
      pf_addr_q   <= RESET_PC;
      mem_pc_q    <= '0;
      mem_req_q   <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cpu_rdy_q   <= 1'b0;
      cpu_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pf_addr_q   <= pf_addr_d;
      mem_pc_q    <= mem_pc_d;
      mem_req_q   <= mem_req_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      cpu_rdy_q   <= cpu_rdy_d;
      cpu_instr_q <= cpu_instr_d;
    end
  end

  // Queue storage write on an accepted memory response.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately not reset; an entry is only ever read
    // when count_q says it holds valid data.
    if (push) begin
      q_addr[wr_ptr_q]  <= mem_pc_q;
      q_instr[wr_ptr_q] <= mem_instruction;
    end
  end

  assign cpu_instruction  = cpu_instr_q;
  assign cpu_instrReady   = cpu_rdy_q;
  assign mem_PC           = mem_pc_q;
  assign mem_instrRequest = mem_req_q;
  assign pf_count         = count_q;

  // Issue is gated on count < DEPTH, so a push into a full queue means the
  // flow control is broken.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(push && (count_q == FULL)));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Self-checking bench for fetch_prefetch_buffer: directed vector table,
// hand-written corner sequences and randomized fetch streams, all checked
// against a transaction-level queue model and a behavioural memory.
module tb_fetch_prefetch_buffer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_PC = '0;
  logic        cpu_instrRequest = 1'b0;
  logic [31:0] cpu_instruction;
  logic        cpu_instrReady;
  logic [31:0] mem_PC;
  logic        mem_instrRequest;
  logic [31:0] mem_data = '0;
  logic        mem_rdy = 1'b0;
  logic [2:0]  pf_count;

  always #5 clock = ~clock;

  fetch_prefetch_buffer #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .INC(4), .RESET_PC(32'h0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_PC           (cpu_PC),
    .cpu_instrRequest (cpu_instrRequest),
    .cpu_instruction  (cpu_instruction),
    .cpu_instrReady   (cpu_instrReady),
    .mem_PC           (mem_PC),
    .mem_instrRequest (mem_instrRequest),
    .mem_instruction  (mem_data),
    .mem_instrReady   (mem_rdy),
    .pf_count         (pf_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // ---------------- behavioural memory ----------------
  int          lat = 3;
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  task automatic mem_step();
    if (mem_rdy) begin
      mem_rdy  = 1'b0;
      mem_busy = 0;
    end else if (mem_busy) begin
      check("mem_pc_stable", mem_PC, mem_addr);
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_rdy  = 1'b1;
        mem_data = instr_of(mem_addr);
      end
    end else if (mem_instrRequest) begin
      mem_busy = 1;
      mem_addr = mem_PC;
      mem_cnt  = lat - 1;
      if (mem_cnt == 0) begin
        mem_rdy  = 1'b1;
        mem_data = instr_of(mem_addr);
      end
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mq[$];
  bit          m_out_valid;
  logic [31:0] m_out_addr;
  bit          m_stale;
  logic [31:0] m_pf;
  bit          m_rdy;
  logic [31:0] m_instr;

  task automatic model_reset();
    mq.delete();
    m_out_valid = 0;
    m_out_addr  = '0;
    m_stale     = 0;
    m_pf        = '0;
    m_rdy       = 0;
    m_instr     = '0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int sz;
    bit ev, hit, pend, redir, push, issue;
    sz    = mq.size();
    ev    = cpu_instrRequest && !m_rdy;
    hit   = ev && (sz > 0) && (mq[0] == cpu_PC);
    pend  = ev && (sz == 0) && (cpu_PC == m_pf);
    redir = ev && !hit && !pend;
    push  = mem_rdy && m_out_valid && !m_stale && !redir;
    issue = !m_out_valid && ((sz < DEPTH) || redir);
    if (hit) begin
      m_instr = instr_of(mq[0]);
      void'(mq.pop_front());
    end
    if (redir) begin
      mq.delete();
      m_pf = cpu_PC;
      if (m_out_valid && !mem_rdy) m_stale = 1;
    end
    if (push) begin
      mq.push_back(m_out_addr);
      m_pf = m_pf + 32'd4;
    end
    if (mem_rdy) m_out_valid = 0;
    if (issue) begin
      m_out_valid = 1;
      m_out_addr  = m_pf;
      m_stale     = 0;
    end
    m_rdy = hit;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("m_count",  32'(pf_count),         32'(mq.size()));
    check("m_ready",  32'(cpu_instrReady),   32'(m_rdy));
    check("m_instr",  cpu_instruction,       m_instr);
    check("m_memreq", 32'(mem_instrRequest), 32'(m_out_valid));
    check("m_mempc",  mem_PC,                m_out_addr);
    mem_step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  32'(cpu_instrReady),   32'd0);
    check({tag, "_instr"},  cpu_instruction,       32'd0);
    check({tag, "_memreq"}, 32'(mem_instrRequest), 32'd0);
    check({tag, "_mempc"},  mem_PC,                32'd0);
    check({tag, "_count"},  32'(pf_count),         32'd0);
  endtask

  // Leaves the bench at a falling edge just after reset release.
  task automatic do_reset();
    reset            = 1'b0;
    cpu_instrRequest = 1'b0;
    cpu_PC           = '0;
    mem_rdy          = 1'b0;
    mem_busy         = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Tick at least once, then until cpu_instrReady or the budget expires.
  task automatic wait_ready(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_instrReady && n < budget);
    check("wait_ready_timeout", 32'(cpu_instrReady), 32'd1);
  endtask

  task automatic wait_mem_rdy(input int budget);
    int n = 0;
    while (!mem_rdy && n < budget) begin
      tick();
      n++;
    end
    check("wait_mem_rdy_timeout", 32'(mem_rdy), 32'd1);
  endtask

  task automatic wait_mem_req(input int budget);
    int n = 0;
    while (!mem_instrRequest && n < budget) begin
      tick();
      n++;
    end
    check("wait_mem_req_timeout", 32'(mem_instrRequest), 32'd1);
  endtask

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        rdy;
    logic [31:0] instr;
    logic        mreq;
    logic [31:0] mpc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] pc;
    int          r;

    // Cold start with 3-cycle memory: pulse on the 5th edge, then PC=4.
    tbl[0] = '{1'b1, 32'h0, 1'b0, 32'h0,          1'b1, 32'h0, 3'd0};
    tbl[1] = '{1'b1, 32'h0, 1'b0, 32'h0,          1'b1, 32'h0, 3'd0};
    tbl[2] = '{1'b1, 32'h0, 1'b0, 32'h0,          1'b1, 32'h0, 3'd0};
    tbl[3] = '{1'b1, 32'h0, 1'b0, 32'h0,          1'b0, 32'h0, 3'd1};
    tbl[4] = '{1'b1, 32'h0, 1'b1, instr_of(32'h0), 1'b1, 32'h4, 3'd0};
    tbl[5] = '{1'b1, 32'h4, 1'b0, instr_of(32'h0), 1'b1, 32'h4, 3'd0};
    tbl[6] = '{1'b1, 32'h4, 1'b0, instr_of(32'h0), 1'b1, 32'h4, 3'd0};
    tbl[7] = '{1'b1, 32'h4, 1'b0, instr_of(32'h0), 1'b0, 32'h4, 3'd1};
    tbl[8] = '{1'b1, 32'h4, 1'b1, instr_of(32'h4), 1'b1, 32'h8, 3'd0};

    lat = 3;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cpu_instrRequest = tbl[i].req;
      cpu_PC           = tbl[i].pc;
      tick();
      check($sformatf("tbl%0d_ready", i),  32'(cpu_instrReady),   32'(tbl[i].rdy));
      check($sformatf("tbl%0d_instr", i),  cpu_instruction,       tbl[i].instr);
      check($sformatf("tbl%0d_memreq", i), 32'(mem_instrRequest), 32'(tbl[i].mreq));
      check($sformatf("tbl%0d_mempc", i),  mem_PC,                tbl[i].mpc);
      check($sformatf("tbl%0d_count", i),  32'(pf_count),         32'(tbl[i].cnt));
    end

    // Fill: no requests, the queue saturates and prefetching stops.
    cpu_instrRequest = 1'b0;
    repeat (20) tick();
    check("fill_count", 32'(pf_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fill_memreq_idle", 32'(mem_instrRequest), 32'd0);
    end

    // Sequential hits out of the full queue: a pulse every other cycle.
    pc               = 32'h8;
    cpu_PC           = pc;
    cpu_instrRequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("seq_ready", 32'(cpu_instrReady), 32'd1);
      check("seq_instr", cpu_instruction, instr_of(pc));
      pc     = pc + 32'd4;
      cpu_PC = pc;
      tick();
      check("seq_gap", 32'(cpu_instrReady), 32'd0);
    end
    cpu_instrRequest = 1'b0;

    // Reset asserted while a fetch is outstanding clears outputs at once.
    wait_mem_req(20);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");

    // Redirect while the fetch of 0x0 is in flight.
    lat = 3;
    do_reset();
    tick();
    check("rd_issue_memreq", 32'(mem_instrRequest), 32'd1);
    check("rd_issue_mempc",  mem_PC, 32'h0);
    cpu_instrRequest = 1'b1;
    cpu_PC           = 32'h100;
    tick();
    check("rd_discard_memreq", 32'(mem_instrRequest), 32'd1);
    check("rd_discard_mempc",  mem_PC, 32'h0);
    check("rd_discard_count",  32'(pf_count), 32'd0);
    wait_mem_rdy(10);
    tick();
    check("rd_drop_memreq", 32'(mem_instrRequest), 32'd0);
    check("rd_drop_count",  32'(pf_count), 32'd0);
    check("rd_drop_ready",  32'(cpu_instrReady), 32'd0);
    tick();
    check("rd_new_memreq", 32'(mem_instrRequest), 32'd1);
    check("rd_new_mempc",  mem_PC, 32'h100);
    wait_ready(20);
    check("rd_instr", cpu_instruction, instr_of(32'h100));

    // Redirect in the very cycle the memory answers.
    cpu_PC = 32'h104;
    wait_mem_rdy(10);
    check("rs_inflight_pc", mem_PC, 32'h104);
    cpu_PC = 32'h200;
    tick();
    check("rs_count",  32'(pf_count), 32'd0);
    check("rs_memreq", 32'(mem_instrRequest), 32'd0);
    check("rs_ready",  32'(cpu_instrReady), 32'd0);
    tick();
    check("rs_new_memreq", 32'(mem_instrRequest), 32'd1);
    check("rs_new_mempc",  mem_PC, 32'h200);

    // Prefetch address wraps past the top of the address space.
    cpu_PC = 32'hFFFF_FFFC;
    wait_ready(30);
    check("wrap_instr", cpu_instruction, instr_of(32'hFFFF_FFFC));
    wait_mem_req(10);
    check("wrap_mempc", mem_PC, 32'h0);

    // Randomized fetch streams, checked cycle by cycle against the model.
    for (int seg = 0; seg < 3; seg++) begin
      lat = $urandom_range(1, 4);
      do_reset();
      pc = '0;
      for (int i = 0; i < 100; i++) begin
        cpu_instrRequest = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        r = $urandom_range(0, 99);
        if (r < 70)      pc = pc + 32'd4;
        else if (r < 80) pc = pc;
        else if (r < 92) pc = 32'($urandom_range(0, 255)) << 2;
        else             pc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
        cpu_PC           = pc;
        cpu_instrRequest = 1'b1;
        wait_ready(60);
        check("rand_instr", cpu_instruction, instr_of(pc));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
